// File: rtl/fmps_mitigation_scan.sv
// Fast MPS mitigation scan.
// Once the gathering stage marks an FA cycle's readout valid, this block walks the FMPS readout
// port and builds trip and missing bitmaps for the enabled nodes. It raises a sticky mitigation
// trip with the lowest offending index, and counts scans that the next FA strobe cuts short.
module fmps_mitigation_scan #(
    parameter int unsigned INDEX_WIDTH   = 5,
    parameter int unsigned OVERRUN_WIDTH = 8
) (
    input  logic                          sysClk,
    input  logic                          sysReset,
    input  logic                          FAstrobe,
    input  logic                          readoutValid,
    input  logic                          readTimeout,
    input  logic [INDEX_WIDTH:0]          fmpsCount,
    input  logic [(2**INDEX_WIDTH)-1:0]   fmpsMask,
    input  logic                          tripOnMissing,
    input  logic                          clearTrip,
    output logic [INDEX_WIDTH-1:0]        fmpsReadoutAddress,
    input  logic [31:0]                   fmpsReadout,
    input  logic                          fmpsReadoutPresent,
    output logic [(2**INDEX_WIDTH)-1:0]   tripBitmap,
    output logic [(2**INDEX_WIDTH)-1:0]   missingBitmap,
    output logic                          resultStrobe,
    output logic                          mitigationTrip,
    output logic [INDEX_WIDTH-1:0]        firstTripIndex,
    output logic [OVERRUN_WIDTH-1:0]      overrunCount
);

    localparam int unsigned NumNodes = 2 ** INDEX_WIDTH;
    localparam int unsigned CountW   = INDEX_WIDTH + 1;

    localparam logic [INDEX_WIDTH:0]     MaxCount   = CountW'(NumNodes);
    localparam logic [INDEX_WIDTH:0]     CountOne   = CountW'(1);
    localparam logic [INDEX_WIDTH-1:0]   AddrOne    = INDEX_WIDTH'(1);
    localparam logic [OVERRUN_WIDTH-1:0] OverrunOne = OVERRUN_WIDTH'(1);

    typedef enum logic [1:0] {
        StIdle,
        StScan,
        StDone
    } stateT;

    stateT                   stateQ, stateD;
    logic                    validDlyQ, timeoutDlyQ;
    logic [INDEX_WIDTH-1:0]  addrQ, addrD;
    logic                    pendQ, pendD;
    logic [INDEX_WIDTH-1:0]  capIdxQ, capIdxD;
    logic [NumNodes-1:0]     scratchTripQ, scratchTripD;
    logic [NumNodes-1:0]     scratchMissQ, scratchMissD;
    logic [NumNodes-1:0]     tripBitmapQ, missingBitmapQ;
    logic                    mitigationTripQ;
    logic [INDEX_WIDTH-1:0]  firstTripIndexQ;
    logic [OVERRUN_WIDTH-1:0] overrunQ;

    logic                    validRise, validFall, timeoutRise;
    logic [INDEX_WIDTH:0]    countClamped;
    logic [INDEX_WIDTH-1:0]  lastIdx;
    logic [NumNodes-1:0]     rangeMask;
    logic [NumNodes-1:0]     offenders;
    logic [INDEX_WIDTH-1:0]  lowestOffender;
    logic                    abortScan;
    logic                    publish;
    logic                    unusedReadoutBits;

    // Only bit 0 of the readout word carries the node trip request.
    assign unusedReadoutBits = ^fmpsReadout[31:1];

    assign validRise   = readoutValid & ~validDlyQ;
    assign validFall   = ~readoutValid & validDlyQ;
    assign timeoutRise = readTimeout & ~timeoutDlyQ;

    assign countClamped = (fmpsCount > MaxCount) ? MaxCount : fmpsCount;
    // Only meaningful when countClamped is non-zero; the zero case never enters the scan.
    assign lastIdx      = INDEX_WIDTH'(countClamped - CountOne);

    assign offenders = tripBitmapQ | (tripOnMissing ? missingBitmapQ : '0);

    // Node range mask and lowest-offender priority encode.
    always_comb begin
        rangeMask      = '0;
        lowestOffender = '0;
        for (int i = 0; i < NumNodes; i++) begin
            rangeMask[i] = (CountW'(i) < countClamped);
        end
        for (int i = NumNodes - 1; i >= 0; i--) begin
            if (offenders[i]) begin
                lowestOffender = INDEX_WIDTH'(i);
            end
        end
    end

    // Next-state, address sequencing and scratch bitmap capture.
    always_comb begin
        stateD       = stateQ;
        addrD        = addrQ;
        pendD        = pendQ;
        capIdxD      = capIdxQ;
        scratchTripD = scratchTripQ;
        scratchMissD = scratchMissQ;
        abortScan    = 1'b0;

        unique case (stateQ)
            StIdle: begin
                addrD = '0;
                pendD = 1'b0;
                // FAstrobe blocks any start, even a coincident readoutValid rise.
                if (!FAstrobe) begin
                    if (validRise) begin
                        scratchTripD = '0;
                        scratchMissD = '0;
                        stateD       = (countClamped == '0) ? StDone : StScan;
                    end else if (timeoutRise) begin
                        scratchTripD = '0;
                        scratchMissD = fmpsMask & rangeMask;
                        stateD       = StDone;
                    end
                end
            end

            StScan: begin
                if (FAstrobe || validFall) begin
                    stateD    = StIdle;
                    addrD     = '0;
                    pendD     = 1'b0;
                    abortScan = 1'b1;
                end else begin
                    // Data on the port belongs to the address driven one cycle earlier.
                    if (pendQ && fmpsMask[capIdxQ]) begin
                        if (!fmpsReadoutPresent) begin
                            scratchMissD[capIdxQ] = 1'b1;
                        end else if (fmpsReadout[0]) begin
                            scratchTripD[capIdxQ] = 1'b1;
                        end
                    end
                    if (pendQ && (capIdxQ >= lastIdx)) begin
                        stateD = StDone;
                        addrD  = '0;
                        pendD  = 1'b0;
                    end else begin
                        pendD   = 1'b1;
                        capIdxD = addrQ;
                        if (addrQ != lastIdx) begin
                            addrD = addrQ + AddrOne;
                        end
                    end
                end
            end

            StDone: begin
                stateD = StIdle;
            end

            default: begin
                stateD = StIdle;
            end
        endcase
    end

    // Bitmaps are published on the edge that enters DONE, so they are visible with resultStrobe.
    assign publish = (stateQ != StDone) && (stateD == StDone);

    // Scan state, edge-detect delays and scratch/published bitmaps.
    always_ff @(posedge sysClk or posedge sysReset) begin
        if (sysReset) begin
            stateQ         <= StIdle;
            validDlyQ      <= 1'b0;
            timeoutDlyQ    <= 1'b0;
            addrQ          <= '0;
            pendQ          <= 1'b0;
            capIdxQ        <= '0;
            scratchTripQ   <= '0;
            scratchMissQ   <= '0;
            tripBitmapQ    <= '0;
            missingBitmapQ <= '0;
        end else begin
            stateQ       <= stateD;
            validDlyQ    <= readoutValid;
            timeoutDlyQ  <= readTimeout;
            addrQ        <= addrD;
            pendQ        <= pendD;
            capIdxQ      <= capIdxD;
            scratchTripQ <= scratchTripD;
            scratchMissQ <= scratchMissD;
            if (publish) begin
                tripBitmapQ    <= scratchTripD;
                missingBitmapQ <= scratchMissD;
            end
        end
    end

    // Sticky trip: set from the freshly published result in DONE; a coincident clear loses.
    always_ff @(posedge sysClk or posedge sysReset) begin
        if (sysReset) begin
            mitigationTripQ <= 1'b0;
            firstTripIndexQ <= '0;
        end else if ((stateQ == StDone) && (offenders != '0) &&
                     (!mitigationTripQ || clearTrip)) begin
            mitigationTripQ <= 1'b1;
            firstTripIndexQ <= lowestOffender;
        end else if (clearTrip) begin
            mitigationTripQ <= 1'b0;
        end
    end

    // Saturating count of scans aborted before completion.
    always_ff @(posedge sysClk or posedge sysReset) begin
        if (sysReset) begin
            overrunQ <= '0;
        end else if (abortScan && (overrunQ != '1)) begin
            overrunQ <= overrunQ + OverrunOne;
        end
    end

    assign fmpsReadoutAddress = addrQ;
    assign tripBitmap         = tripBitmapQ;
    assign missingBitmap      = missingBitmapQ;
    assign resultStrobe       = (stateQ == StDone);
    assign mitigationTrip     = mitigationTripQ;
    assign firstTripIndex     = firstTripIndexQ;
    assign overrunCount       = overrunQ;

endmodule

// File: tb/tb_fmps_mitigation_scan.sv
// Bench for fmps_mitigation_scan: directed cases plus randomized scans, timeouts and aborts,
// checked against a bitmap-level reference model.
module tb_fmps_mitigation_scan;

    logic        sysClk = 1'b0;
    logic        sysReset;
    logic        FAstrobe;
    logic        readoutValid;
    logic        readTimeout;
    logic [5:0]  fmpsCount;
    logic [31:0] fmpsMask;
    logic        tripOnMissing;
    logic        clearTrip;
    logic [4:0]  fmpsReadoutAddress;
    logic [31:0] fmpsReadout;
    logic        fmpsReadoutPresent;
    logic [31:0] tripBitmap;
    logic [31:0] missingBitmap;
    logic        resultStrobe;
    logic        mitigationTrip;
    logic [4:0]  firstTripIndex;
    logic [7:0]  overrunCount;

    // Readout memory contents and reference model state.
    logic [31:0] memTrip;
    logic [31:0] memPresent;
    logic [31:0] expTripBm;
    logic [31:0] expMissBm;
    logic        expTrip;
    logic [4:0]  expIdx;
    int          expOverrun;

    int vectors     = 0;
    int miscompares = 0;

    always #5 sysClk = ~sysClk;

    fmps_mitigation_scan #(
        .INDEX_WIDTH   (5),
        .OVERRUN_WIDTH (8)
    ) dut (
        .sysClk             (sysClk),
        .sysReset           (sysReset),
        .FAstrobe           (FAstrobe),
        .readoutValid       (readoutValid),
        .readTimeout        (readTimeout),
        .fmpsCount          (fmpsCount),
        .fmpsMask           (fmpsMask),
        .tripOnMissing      (tripOnMissing),
        .clearTrip          (clearTrip),
        .fmpsReadoutAddress (fmpsReadoutAddress),
        .fmpsReadout        (fmpsReadout),
        .fmpsReadoutPresent (fmpsReadoutPresent),
        .tripBitmap         (tripBitmap),
        .missingBitmap      (missingBitmap),
        .resultStrobe       (resultStrobe),
        .mitigationTrip     (mitigationTrip),
        .firstTripIndex     (firstTripIndex),
        .overrunCount       (overrunCount)
    );

    task automatic checkValue(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Advance one cycle; the readout port answers the address driven in the cycle just ended.
    task automatic tick();
        logic [4:0] a;
        a = fmpsReadoutAddress;
        @(posedge sysClk);
        #1;
        fmpsReadout        = $urandom();
        fmpsReadout[0]     = memTrip[a];
        fmpsReadoutPresent = memPresent[a];
    endtask

    function automatic int clampN(input int n);
        return (n > 32) ? 32 : n;
    endfunction

    function automatic logic [31:0] countMask(input int n);
        logic [31:0] m;
        m = '0;
        for (int i = 0; i < 32; i++) begin
            if (i < n) m[i] = 1'b1;
        end
        return m;
    endfunction

    function automatic logic [4:0] lowestIndex(input logic [31:0] v);
        for (int i = 0; i < 32; i++) begin
            if (v[i]) return 5'(i);
        end
        return 5'd0;
    endfunction

    // Called in the strobe cycle: check the result, then the trip state one cycle later.
    task automatic finishResult(input logic clr);
        logic [31:0] off;
        checkValue("resultStrobe", 64'(resultStrobe), 64'(1));
        checkValue("tripBitmap", 64'(tripBitmap), 64'(expTripBm));
        checkValue("missingBitmap", 64'(missingBitmap), 64'(expMissBm));
        clearTrip = clr;
        tick();
        clearTrip = 1'b0;
        off = expTripBm | (tripOnMissing ? expMissBm : 32'h0);
        if ((off != 0) && (!expTrip || clr)) begin
            expTrip = 1'b1;
            expIdx  = lowestIndex(off);
        end else if (clr) begin
            expTrip = 1'b0;
        end
        checkValue("strobeOnePulse", 64'(resultStrobe), 64'(0));
        checkValue("mitigationTrip", 64'(mitigationTrip), 64'(expTrip));
        checkValue("firstTripIndex", 64'(firstTripIndex), 64'(expIdx));
    endtask

    task automatic runScan(input int n, input logic [31:0] mask, input logic tom,
                           input logic clr, input logic tmo);
        int nc;
        int s;
        nc = clampN(n);
        fmpsCount     = 6'(n);
        fmpsMask      = mask;
        tripOnMissing = tom;
        readoutValid  = 1'b1;
        expTripBm = memTrip & memPresent & mask & countMask(nc);
        expMissBm = ~memPresent & mask & countMask(nc);
        s = (nc == 0) ? 1 : nc + 2;
        for (int c = 1; c < s; c++) begin
            tick();
            if (c == 1) readTimeout = tmo;
            if (c <= nc) checkValue("readoutAddress", 64'(fmpsReadoutAddress), 64'(c - 1));
            checkValue("strobeEarly", 64'(resultStrobe), 64'(0));
        end
        tick();
        finishResult(clr);
        readoutValid = 1'b0;
        readTimeout  = 1'b0;
        tick();
        tick();
    endtask

    task automatic runTimeout(input int n, input logic [31:0] mask, input logic tom,
                              input logic clr);
        fmpsCount     = 6'(n);
        fmpsMask      = mask;
        tripOnMissing = tom;
        readTimeout   = 1'b1;
        expTripBm = '0;
        expMissBm = mask & countMask(clampN(n));
        tick();
        finishResult(clr);
        readTimeout = 1'b0;
        tick();
        tick();
    endtask

    // Abort in SCAN cycle k (1..nc+1), by FAstrobe or by readoutValid falling.
    task automatic runAbort(input int n, input int k, input logic useFa);
        int nc;
        nc = clampN(n);
        fmpsCount    = 6'(n);
        readoutValid = 1'b1;
        for (int c = 1; c <= k; c++) begin
            tick();
            checkValue("strobeInScan", 64'(resultStrobe), 64'(0));
        end
        if (useFa) FAstrobe = 1'b1;
        else readoutValid = 1'b0;
        tick();
        FAstrobe     = 1'b0;
        readoutValid = 1'b0;
        expOverrun = (expOverrun < 255) ? expOverrun + 1 : 255;
        checkValue("overrunCount", 64'(overrunCount), 64'(expOverrun));
        checkValue("addrAfterAbort", 64'(fmpsReadoutAddress), 64'(0));
        for (int c = 0; c < nc + 2; c++) begin
            tick();
            checkValue("strobeAfterAbort", 64'(resultStrobe), 64'(0));
        end
        checkValue("tripBitmapKept", 64'(tripBitmap), 64'(expTripBm));
        checkValue("missingBitmapKept", 64'(missingBitmap), 64'(expMissBm));
    endtask

    task automatic pulseClear();
        clearTrip = 1'b1;
        tick();
        clearTrip = 1'b0;
        expTrip = 1'b0;
        checkValue("tripCleared", 64'(mitigationTrip), 64'(0));
        checkValue("indexKeptOnClear", 64'(firstTripIndex), 64'(expIdx));
    endtask

    task automatic checkAllZero(input string tag);
        checkValue({tag, "Addr"}, 64'(fmpsReadoutAddress), 64'(0));
        checkValue({tag, "Trip"}, 64'(tripBitmap), 64'(0));
        checkValue({tag, "Miss"}, 64'(missingBitmap), 64'(0));
        checkValue({tag, "Strobe"}, 64'(resultStrobe), 64'(0));
        checkValue({tag, "Mitig"}, 64'(mitigationTrip), 64'(0));
        checkValue({tag, "Index"}, 64'(firstTripIndex), 64'(0));
        checkValue({tag, "Overrun"}, 64'(overrunCount), 64'(0));
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not reach the end");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int sel;
        int n;
        int k;
        logic [31:0] mask;

        sysReset           = 1'b1;
        FAstrobe           = 1'b0;
        readoutValid       = 1'b0;
        readTimeout        = 1'b0;
        fmpsCount          = '0;
        fmpsMask           = '0;
        tripOnMissing      = 1'b0;
        clearTrip          = 1'b0;
        fmpsReadout        = '0;
        fmpsReadoutPresent = 1'b0;
        memTrip            = '0;
        memPresent         = '1;
        expTripBm          = '0;
        expMissBm          = '0;
        expTrip            = 1'b0;
        expIdx             = '0;
        expOverrun         = 0;

        repeat (2) @(posedge sysClk);
        #1;
        checkAllZero("reset");
        sysReset = 1'b0;
        tick();

        // All present, no trips.
        memTrip = '0; memPresent = '1;
        runScan(4, 32'hF, 1'b0, 1'b0, 1'b0);

        // Nodes 5 and 2 trip, then node 1 alone: index stays at the first latch.
        memTrip = 32'h24;
        runScan(8, 32'hFF, 1'b0, 1'b0, 1'b0);
        memTrip = 32'h02;
        runScan(8, 32'hFF, 1'b0, 1'b0, 1'b0);

        // Node 4 absent, without and with tripOnMissing.
        pulseClear();
        memTrip = '0; memPresent = ~32'h10;
        runScan(6, 32'h3F, 1'b0, 1'b0, 1'b0);
        runScan(6, 32'h3F, 1'b1, 1'b0, 1'b0);

        // Timeout in IDLE.
        pulseClear();
        runTimeout(3, 32'hFF, 1'b1, 1'b0);
        tripOnMissing = 1'b0;

        // FAstrobe abort mid-scan.
        runAbort(20, 10, 1'b1);

        // clearTrip coinciding with DONE: trip wins and the index re-latches.
        memTrip = 32'h80; memPresent = '1;
        runScan(8, 32'hFF, 1'b0, 1'b1, 1'b0);
        pulseClear();

        // Count above the node count clamps; a timeout during a scan is ignored.
        memTrip = 32'h8000_0001; memPresent = 32'hFFFF_FFFE;
        runScan(40, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b1);
        runScan(0, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0);

        // Randomized mix.
        repeat (40) begin
            sel  = $urandom_range(0, 3);
            n    = $urandom_range(0, 40);
            mask = $urandom();
            memTrip    = $urandom() & $urandom() & $urandom();
            memPresent = $urandom() | $urandom();
            case (sel)
                0, 1: runScan(n, mask, 1'($urandom_range(0, 1)),
                              ($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)));
                2: runTimeout(n, mask, 1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0));
                default: begin
                    n = $urandom_range(2, 40);
                    k = $urandom_range(1, clampN(n) + 1);
                    runAbort(n, k, 1'($urandom_range(0, 1)));
                end
            endcase
            if ($urandom_range(0, 4) == 0) pulseClear();
        end

        // Asynchronous reset in the middle of a scan.
        memTrip = '0; memPresent = '1;
        fmpsCount = 6'd10; fmpsMask = '1; readoutValid = 1'b1;
        repeat (3) tick();
        #2;
        sysReset = 1'b1;
        #1;
        checkAllZero("asyncReset");
        expTripBm = '0; expMissBm = '0; expTrip = 1'b0; expIdx = '0; expOverrun = 0;
        readoutValid = 1'b0;
        tick();
        sysReset = 1'b0;
        tick();

        // Overrun saturation over 300 aborts.
        fmpsCount = 6'd20;
        repeat (300) begin
            readoutValid = 1'b1;
            tick();
            FAstrobe = 1'b1;
            tick();
            FAstrobe = 1'b0;
            readoutValid = 1'b0;
            tick();
            expOverrun = (expOverrun < 255) ? expOverrun + 1 : 255;
        end
        checkValue("overrunSaturated", 64'(overrunCount), 64'(expOverrun));
        checkValue("noStrobeAfterAborts", 64'(resultStrobe), 64'(0));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
